// File: rtl/siaminer_pkg.sv
// Shared constants and helpers for the miner datapath blocks.
package siaminer_pkg;

   localparam int unsigned M04_W        = 64;
   localparam int unsigned DEF_DEPTH    = 4;
   localparam int unsigned DEF_HOLD_CYC = 2;
   localparam int unsigned DEF_CNT_W    = 16;

   // Bits needed to encode values 0..n-1 (0 for n<=1).
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/elastic_flush_stage.sv
// One valid/data register of the elastic pipe: load from upstream, flush-clear, async reset.
module elastic_flush_stage
   import siaminer_pkg::*;
#(
   parameter int unsigned DATA_W = M04_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              load,
   input  logic              src_v,
   input  logic [DATA_W-1:0] src_d,
   output logic              v,
   output logic [DATA_W-1:0] d
);

   logic              v_q, v_d;
   logic [DATA_W-1:0] d_q, d_d;

   // Data is only captured alongside a valid source so bubbles keep the last word.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush) begin
         v_d = 1'b0;
         d_d = '0;
      end else if (load) begin
         v_d = src_v;
         if (src_v) d_d = src_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v = v_q;
   assign d = d_q;

endmodule

// File: rtl/elastic_flush_pipe.sv
// DEPTH-stage valid/ready elastic pipe with flush-on-found, post-flush input hold,
// occupancy tracking and a saturating count of words discarded by flushes.
module elastic_flush_pipe
   import siaminer_pkg::*;
#(
   parameter int unsigned DATA_W   = M04_W,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         found,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [clog2(DEPTH+1)-1:0]    occupancy,
   output logic [CNT_W-1:0]             drop_cnt
);

   localparam int unsigned OCC_W  = clog2(DEPTH + 1);
   localparam int unsigned HOLD_W = (HOLD_CYC > 0) ? clog2(HOLD_CYC + 1) : 1;
   localparam int unsigned SUM_W  = CNT_W + 1;

   logic              stage_v [DEPTH];
   logic [DATA_W-1:0] stage_d [DEPTH];
   logic              src_v   [DEPTH];
   logic [DATA_W-1:0] src_d   [DEPTH];
   logic              rdy     [DEPTH];

   logic              in_fire, out_fire;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [SUM_W-1:0]  drop_sum;
   logic              rdy_acc;

   // rdy[i] = !v[i] | rdy[i+1], unrolled from the tail with an accumulator so the
   // chain stays a plain combinational OR rather than a self-referencing vector.
   always_comb begin
      rdy_acc = out_ready;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         rdy_acc              = rdy_acc | ~stage_v[DEPTH-1-k];
         rdy[DEPTH-1-k]       = rdy_acc;
      end
   end

   assign in_ready  = rdy[0] & ~found & (hold_q == '0);
   assign in_fire   = in_valid & in_ready;
   assign out_valid = stage_v[DEPTH-1] & ~found;
   assign out_fire  = out_valid & out_ready;
   assign out_data  = stage_d[DEPTH-1];

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign src_v[i] = in_fire;
         assign src_d[i] = in_data;
      end else begin : g_body
         assign src_v[i] = stage_v[i-1];
         assign src_d[i] = stage_d[i-1];
      end

      elastic_flush_stage #(
         .DATA_W (DATA_W)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .flush (found),
         .load  (rdy[i]),
         .src_v (src_v[i]),
         .src_d (src_d[i]),
         .v     (stage_v[i]),
         .d     (stage_d[i])
      );
   end

   assign drop_sum = SUM_W'(drop_q) + SUM_W'(occ_q);

   always_comb begin
      occ_d  = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
      hold_d = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
      drop_d = drop_q;
      if (found) begin
         occ_d  = '0;
         hold_d = HOLD_W'(HOLD_CYC);
         drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q  <= '0;
         hold_q <= '0;
         drop_q <= '0;
      end else begin
         occ_q  <= occ_d;
         hold_q <= hold_d;
         drop_q <= drop_d;
      end
   end

   assign occupancy = occ_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_elastic_flush_pipe.sv
// Self-checking bench for elastic_flush_pipe: vector table, directed corner sequences,
// and randomized traffic against a positional queue model of the pipe.
module tb_elastic_flush_pipe;

   localparam int DEPTH = 4;
   localparam int HOLD  = 2;
   localparam int DMAX  = 65535;

   logic        clk = 1'b0;
   logic        rst;
   logic        found, in_valid, out_ready;
   logic [63:0] in_data, out_data;
   logic        in_ready, out_valid;
   logic [2:0]  occupancy;
   logic [15:0] drop_cnt;

   logic        s_found, s_in_valid, s_out_ready;
   logic [63:0] s_in_data, s_out_data;
   logic        s_in_ready, s_out_valid;
   logic [2:0]  s_occupancy;
   logic [3:0]  s_drop_cnt;

   always #5 clk = ~clk;

   elastic_flush_pipe #(
      .DATA_W (64), .DEPTH (DEPTH), .HOLD_CYC (HOLD), .CNT_W (16)
   ) dut (
      .clk (clk), .rst (rst), .found (found),
      .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .occupancy (occupancy), .drop_cnt (drop_cnt)
   );

   // Narrow drop counter so saturation is reachable in a few flushes.
   elastic_flush_pipe #(
      .DATA_W (64), .DEPTH (DEPTH), .HOLD_CYC (HOLD), .CNT_W (4)
   ) dut_s (
      .clk (clk), .rst (rst), .found (s_found),
      .in_valid (s_in_valid), .in_ready (s_in_ready), .in_data (s_in_data),
      .out_valid (s_out_valid), .out_ready (s_out_ready), .out_data (s_out_data),
      .occupancy (s_occupancy), .drop_cnt (s_drop_cnt)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Model: words in arrival order, each with its stage position.
   logic [63:0] qd [$];
   int          qp [$];
   int          np_a [DEPTH];
   int          hold_m, drop_m;
   logic [63:0] tail_m;
   logic        p_in_ready, p_out_valid;

   task automatic model_reset();
      qd.delete();
      qp.delete();
      hold_m = 0;
      drop_m = 0;
      tail_m = '0;
   endtask

   task automatic model_predict();
      int bound;
      bound = out_ready ? DEPTH + 1 : DEPTH;
      for (int j = 0; j < qp.size(); j++) begin
         np_a[j] = (qp[j] + 1 < bound) ? qp[j] + 1 : qp[j];
         bound   = np_a[j];
      end
      p_in_ready  = !found && hold_m == 0 && (qp.size() == 0 || np_a[qp.size()-1] > 0);
      p_out_valid = !found && qp.size() > 0 && qp[0] == DEPTH - 1;
   endtask

   task automatic model_update();
      if (found) begin
         drop_m = (drop_m + qp.size() > DMAX) ? DMAX : drop_m + qp.size();
         qd.delete();
         qp.delete();
         tail_m = '0;
         hold_m = HOLD;
      end else begin
         for (int j = 0; j < qp.size(); j++) begin
            if (np_a[j] == DEPTH - 1 && qp[j] != DEPTH - 1) tail_m = qd[j];
            qp[j] = np_a[j];
         end
         if (qp.size() > 0 && qp[0] == DEPTH) begin
            void'(qp.pop_front());
            void'(qd.pop_front());
         end
         if (in_valid && p_in_ready) begin
            qd.push_back(in_data);
            qp.push_back(0);
            if (DEPTH == 1) tail_m = in_data;
         end
         if (hold_m > 0) hold_m--;
      end
   endtask

   task automatic drive(input logic iv, input logic [63:0] id, input logic ordy, input logic fnd);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      found     = fnd;
   endtask

   task automatic sample();
      @(negedge clk);
      model_predict();
      chk("m_in_ready",  64'(in_ready),  64'(p_in_ready));
      chk("m_out_valid", 64'(out_valid), 64'(p_out_valid));
      chk("m_out_data",  out_data,       tail_m);
      chk("m_occupancy", 64'(occupancy), 64'(qp.size()));
      chk("m_drop_cnt",  64'(drop_cnt),  64'(drop_m));
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step(input logic iv, input logic [63:0] id, input logic ordy, input logic fnd);
      drive(iv, id, ordy, fnd);
      sample();
      advance();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      s_found = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_in_data = '0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data",  out_data,       64'h0);
      chk("rst_occupancy", 64'(occupancy), 64'h0);
      chk("rst_drop_cnt",  64'(drop_cnt),  64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Load n words into the narrow instance, flush them, check the saturating count.
   task automatic s_flush(input int n, input logic [3:0] exp);
      for (int i = 0; i < n; i++) begin
         s_in_valid = 1'b1; s_in_data = 64'(i + 1); s_out_ready = 1'b0; s_found = 1'b0;
         step(1'b0, 64'h0, 1'b1, 1'b0);
      end
      s_in_valid = 1'b0; s_found = 1'b1;
      step(1'b0, 64'h0, 1'b1, 1'b0);
      s_found = 1'b0;
      chk("sat_drop_cnt",  64'(s_drop_cnt),  64'(exp));
      chk("sat_occupancy", 64'(s_occupancy), 64'h0);
      chk("sat_out_valid", 64'(s_out_valid), 64'h0);
      chk("sat_out_data",  s_out_data,       64'h0);
      step(1'b0, 64'h0, 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);
      chk("sat_in_ready",  64'(s_in_ready),  64'h1);
   endtask

   typedef struct {
      logic        iv;
      logic [63:0] id;
      logic        ordy;
      logic        fnd;
      logic        e_ir;
      logic        e_ov;
      logic [63:0] e_od;
      logic [2:0]  e_occ;
      logic [15:0] e_drop;
   } vec_t;

   vec_t tbl [13];

   initial begin
      // Stream 0x1..0x8 with out_ready held high: first word at +4, no gaps.
      tbl[0]  = '{1'b1, 64'h1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 3'd0, 16'd0};
      tbl[1]  = '{1'b1, 64'h2, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 3'd1, 16'd0};
      tbl[2]  = '{1'b1, 64'h3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 3'd2, 16'd0};
      tbl[3]  = '{1'b1, 64'h4, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 3'd3, 16'd0};
      tbl[4]  = '{1'b1, 64'h5, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1, 3'd4, 16'd0};
      tbl[5]  = '{1'b1, 64'h6, 1'b1, 1'b0, 1'b1, 1'b1, 64'h2, 3'd4, 16'd0};
      tbl[6]  = '{1'b1, 64'h7, 1'b1, 1'b0, 1'b1, 1'b1, 64'h3, 3'd4, 16'd0};
      tbl[7]  = '{1'b1, 64'h8, 1'b1, 1'b0, 1'b1, 1'b1, 64'h4, 3'd4, 16'd0};
      tbl[8]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h5, 3'd4, 16'd0};
      tbl[9]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h6, 3'd3, 16'd0};
      tbl[10] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h7, 3'd2, 16'd0};
      tbl[11] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8, 3'd1, 16'd0};
      tbl[12] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h8, 3'd0, 16'd0};

      rst = 1'b1;
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      s_found = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_in_data = '0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      for (int r = 0; r < 13; r++) begin
         drive(tbl[r].iv, tbl[r].id, tbl[r].ordy, tbl[r].fnd);
         sample();
         chk($sformatf("tbl%0d_in_ready", r),  64'(in_ready),  64'(tbl[r].e_ir));
         chk($sformatf("tbl%0d_out_valid", r), 64'(out_valid), 64'(tbl[r].e_ov));
         chk($sformatf("tbl%0d_out_data", r),  out_data,       tbl[r].e_od);
         chk($sformatf("tbl%0d_occupancy", r), 64'(occupancy), 64'(tbl[r].e_occ));
         chk($sformatf("tbl%0d_drop_cnt", r),  64'(drop_cnt),  64'(tbl[r].e_drop));
         advance();
      end

      // Stall: fill with out_ready low, then drain in order.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 64'h21 + 64'(i), 1'b0, 1'b0);
      drive(1'b1, 64'h25, 1'b0, 1'b0);
      sample();
      chk("stall_in_ready",  64'(in_ready),  64'h0);
      chk("stall_occupancy", 64'(occupancy), 64'h4);
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 64'h0, 1'b1, 1'b0);
         sample();
         chk("drain_out_valid", 64'(out_valid), 64'h1);
         chk("drain_out_data",  out_data,       64'h21 + 64'(i));
         advance();
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      sample();
      chk("drain_in_ready",  64'(in_ready),  64'h1);
      chk("drain_occupancy", 64'(occupancy), 64'h0);
      advance();

      // Single-cycle flush with 3 words, tail word visible.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 64'h31 + 64'(i), 1'b0, 1'b0);
      step(1'b0, 64'h0, 1'b0, 1'b0);
      drive(1'b1, 64'h34, 1'b1, 1'b1);
      sample();
      chk("flush_out_valid", 64'(out_valid), 64'h0);
      chk("flush_in_ready",  64'(in_ready),  64'h0);
      advance();
      drive(1'b1, 64'h35, 1'b1, 1'b0);
      sample();
      chk("flush_occupancy", 64'(occupancy), 64'h0);
      chk("flush_drop_cnt",  64'(drop_cnt),  64'h3);
      chk("hold1_in_ready",  64'(in_ready),  64'h0);
      advance();
      sample();
      chk("hold2_in_ready",  64'(in_ready),  64'h0);
      advance();
      sample();
      chk("hold_end_in_ready", 64'(in_ready), 64'h1);
      advance();

      // found on 3 consecutive cycles with a full pipe: counted once, hold restarts.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 64'h41 + 64'(i), 1'b0, 1'b0);
      step(1'b1, 64'h45, 1'b1, 1'b1);
      drive(1'b1, 64'h46, 1'b1, 1'b1);
      sample();
      chk("multi_drop_first", 64'(drop_cnt), 64'h4);
      advance();
      step(1'b1, 64'h47, 1'b1, 1'b1);
      drive(1'b1, 64'h48, 1'b1, 1'b0);
      sample();
      chk("multi_drop_cnt", 64'(drop_cnt),  64'h4);
      chk("multi_hold1",    64'(in_ready),  64'h0);
      advance();
      sample();
      chk("multi_hold2",    64'(in_ready),  64'h0);
      advance();
      sample();
      chk("multi_release",  64'(in_ready),  64'h1);
      advance();

      // Saturation on the narrow counter: 4+4+4+2 = 14, then +4 clamps at 15.
      do_reset();
      s_flush(4, 4'd4);
      s_flush(4, 4'd8);
      s_flush(4, 4'd12);
      s_flush(2, 4'd14);
      s_flush(4, 4'd15);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         step($urandom_range(0, 9) < 7, {$urandom, $urandom},
              $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0);
      end

      // Asynchronous reset in the middle of a hold.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 64'h61 + 64'(i), 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b1);
      chk("pre_rst_drop", 64'(drop_cnt), 64'h3);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'h0);
      chk("arst_out_data",  out_data,       64'h0);
      chk("arst_occupancy", 64'(occupancy), 64'h0);
      chk("arst_drop_cnt",  64'(drop_cnt),  64'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      sample();
      chk("arst_in_ready", 64'(in_ready), 64'h1);
      advance();
      step(1'b1, 64'h71, 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
